// File: rtl/qmult_pipe.sv
// qmult_pipe: pipelined signed Q-format multiplier with valid/ready stream,
// optional round-to-nearest and saturation, per-sample and sticky overflow flags.
module qmult_pipe #(
  parameter int unsigned N      = 32,
  parameter int unsigned Q      = 18,
  parameter int unsigned STAGES = 3,
  parameter int unsigned ROUND  = 1,
  parameter int unsigned SAT    = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] o_result,
  output logic         ovr,
  output logic         ovr_sticky,
  input  logic         clr_sticky
);

  localparam int unsigned PW = 2 * N;
  localparam int unsigned RW = 2 * N + 1;
  localparam int unsigned HW = N + 2 - Q;
  localparam logic [RW-1:0] RND_ADD = (ROUND != 0) ? (RW'(1) << (Q - 1)) : '0;

  logic                 w_adv;
  logic                 w_consume;
  logic signed [N-1:0]  r_a;
  logic signed [N-1:0]  r_b;
  logic                 r_v1;
  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] w_pfin;
  logic                 w_vfin;
  logic [RW-1:0]        w_r;
  logic [HW-1:0]        w_hi;
  logic                 w_ovf;
  logic [N-1:0]         w_res;
  logic                 w_unused_lsb;
  logic                 r_ov;
  logic [N-1:0]         r_result;
  logic                 r_ovr;
  logic                 r_sticky;

  // Global stall: every stage holds while the output is occupied and not taken.
  assign w_adv     = out_ready | ~r_ov;
  assign w_consume = r_ov & out_ready;
  assign in_ready  = w_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a  <= '0;
      r_b  <= '0;
      r_v1 <= 1'b0;
    end else if (w_adv) begin
      r_a  <= a;
      r_b  <= b;
      r_v1 <= in_valid;
    end
  end

  // Operands widened first so the product is exact, including (-2^(N-1))^2.
  assign w_prod = PW'(r_a) * PW'(r_b);

  if (STAGES == 2) begin : g_direct
    assign w_pfin = w_prod;
    assign w_vfin = r_v1;
  end else begin : g_retime
    localparam int unsigned NP = STAGES - 2;
    logic [NP-1:0][PW-1:0] r_p;
    logic [NP-1:0]         r_pv;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_p  <= '0;
        r_pv <= '0;
      end else if (w_adv) begin
        r_p[0]  <= w_prod;
        r_pv[0] <= r_v1;
        for (int unsigned i = 1; i < NP; i++) begin
          r_p[i]  <= r_p[i-1];
          r_pv[i] <= r_pv[i-1];
        end
      end
    end

    assign w_pfin = $signed(r_p[NP-1]);
    assign w_vfin = r_pv[NP-1];
  end

  // One extra bit keeps the rounding carry; overflow means the bits above the
  // kept field disagree with the result sign.
  assign w_r          = {w_pfin[PW-1], w_pfin} + RND_ADD;
  assign w_hi         = w_r[RW-1:N-1+Q];
  assign w_ovf        = ~((w_hi == '0) | (w_hi == '1));
  assign w_unused_lsb = ^w_r[Q-1:0];

  always_comb begin
    w_res = w_r[N-1+Q:Q];
    if ((SAT != 0) && w_ovf) begin
      w_res = w_r[RW-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ov     <= 1'b0;
      r_result <= '0;
      r_ovr    <= 1'b0;
    end else if (w_adv) begin
      r_ov     <= w_vfin;
      r_result <= w_res;
      r_ovr    <= w_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (w_consume & r_ovr) begin
      r_sticky <= 1'b1;
    end else if (clr_sticky) begin
      r_sticky <= 1'b0;
    end
  end

  assign out_valid  = r_ov;
  assign o_result   = r_result;
  assign ovr        = r_ovr;
  assign ovr_sticky = r_sticky;

endmodule

// File: tb/tb_qmult_pipe.sv
// Bench for qmult_pipe: four instances (all ROUND/SAT combinations) share one
// stimulus stream and are compared every cycle against a latency-queue model.
`timescale 1ns/1ps
module tb_qmult_pipe;

  localparam int unsigned N      = 32;
  localparam int unsigned Q      = 18;
  localparam int unsigned STAGES = 3;
  localparam int unsigned NI     = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           out_ready;
  logic           clr_sticky;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic [NI-1:0]  ir_o;
  logic [NI-1:0]  ov_o;
  logic [NI-1:0]  ovr_o;
  logic [NI-1:0]  st_o;
  logic [N-1:0]   res_o [NI];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Instance i: ROUND = (i even), SAT = (i < 2).
  for (genvar g = 0; g < NI; g++) begin : g_dut
    qmult_pipe #(
      .N(N), .Q(Q), .STAGES(STAGES),
      .ROUND((g % 2 == 0) ? 1 : 0),
      .SAT((g < 2) ? 1 : 0)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(ir_o[g]),
      .a(a), .b(b),
      .out_valid(ov_o[g]), .out_ready(out_ready),
      .o_result(res_o[g]), .ovr(ovr_o[g]),
      .ovr_sticky(st_o[g]), .clr_sticky(clr_sticky)
    );
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: exact integer arithmetic on the real-valued product.
  function automatic void model(input logic [N-1:0] va, input logic [N-1:0] vb,
                                input bit rnd, input bit sat,
                                output logic [N-1:0] r, output logic o);
    longint p, q, mx, mn;
    mx = (longint'(1) << (N - 1)) - 1;
    mn = -(longint'(1) << (N - 1));
    p  = longint'($signed(va)) * longint'($signed(vb));
    if (rnd) p = p + (longint'(1) << (Q - 1));
    q = p >>> Q;
    o = (q > mx) || (q < mn);
    if (o && sat) q = (q < 0) ? mn : mx;
    r = N'(q);
  endfunction

  typedef struct packed {
    logic                  v;
    logic [NI-1:0][N-1:0]  res;
    logic [NI-1:0]         ov;
  } slot_t;

  slot_t         pipe[$];
  slot_t         m_last;
  slot_t         m_new;
  slot_t         m_out;
  logic [NI-1:0] m_sticky;
  int            n_consumed = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe.delete();
      for (int i = 0; i < STAGES; i++) pipe.push_back('0);
      m_sticky = '0;
    end else begin
      m_last = pipe[STAGES-1];
      for (int i = 0; i < NI; i++) begin
        if (m_last.v && out_ready && m_last.ov[i]) m_sticky[i] = 1'b1;
        else if (clr_sticky)                        m_sticky[i] = 1'b0;
      end
      if (m_last.v && out_ready) n_consumed++;
      if (out_ready || !m_last.v) begin
        m_new   = '0;
        m_new.v = in_valid;
        for (int i = 0; i < NI; i++) begin
          logic [N-1:0] r;
          logic         o;
          model(a, b, (i % 2 == 0), (i < 2), r, o);
          m_new.res[i] = r;
          m_new.ov[i]  = o;
        end
        pipe.push_front(m_new);
        void'(pipe.pop_back());
      end
    end
  end

  logic [NI-1:0] prev_stall = '0;
  logic [NI-1:0] prev_ovr;
  logic [N-1:0]  prev_res [NI];

  always @(negedge clk) begin
    if (rst_n && pipe.size() == STAGES) begin
      m_out = pipe[STAGES-1];
      for (int i = 0; i < NI; i++) begin
        check($sformatf("out_valid[%0d]", i), ov_o[i], m_out.v);
        check($sformatf("in_ready[%0d]", i), ir_o[i], out_ready || !m_out.v);
        check($sformatf("ovr_sticky[%0d]", i), st_o[i], m_sticky[i]);
        if (m_out.v) begin
          check($sformatf("o_result[%0d]", i), res_o[i], m_out.res[i]);
          check($sformatf("ovr[%0d]", i), ovr_o[i], m_out.ov[i]);
        end
        if (prev_stall[i]) begin
          check($sformatf("stall_hold_res[%0d]", i), res_o[i], prev_res[i]);
          check($sformatf("stall_hold_ovr[%0d]", i), ovr_o[i], prev_ovr[i]);
        end
        prev_stall[i] = ov_o[i] && !out_ready;
        prev_res[i]   = res_o[i];
        prev_ovr[i]   = ovr_o[i];
      end
    end else begin
      prev_stall = '0;
    end
  end

  // One isolated transaction; returns at the cycle the result is presented.
  task automatic run_one(input logic [N-1:0] va, input logic [N-1:0] vb, output int lat);
    in_valid  = 1'b1;
    a         = va;
    b         = vb;
    out_ready = 1'b1;
    lat       = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      lat++;
      in_valid = 1'b0;
      if (ov_o[0]) break;
    end
    if (!ov_o[0]) lat = -1;
  endtask

  function automatic logic [N-1:0] rand_op();
    logic [N-1:0] v;
    case ($urandom_range(0, 4))
      0: v = $urandom();
      1: v = $urandom_range(0, 32'h003FFFFF) - 32'h00200000;
      2: begin
        case ($urandom_range(0, 5))
          0:       v = 32'h80000000;
          1:       v = 32'h7FFFFFFF;
          2:       v = 32'hFFFFFFFF;
          3:       v = 32'h00000001;
          4:       v = 32'h00000000;
          default: v = 32'h00040000;
        endcase
      end
      default: v = $signed($urandom()) >>> $urandom_range(4, 16);
    endcase
    return v;
  endfunction

  logic [N-1:0] bp_a [5] = '{32'h00040000, 32'h00080000, 32'hFFF40000, 32'h00140000, 32'h01000000};
  logic [N-1:0] bp_b [5] = '{32'h00028000, 32'h00060000, 32'h00030000, 32'hFFFE0000, 32'h00100000};

  initial begin
    int lat;
    int idx;
    int n0;
    bit acc;
    logic [NI-1:0] seen;

    in_valid   = 1'b0;
    out_ready  = 1'b1;
    clr_sticky = 1'b0;
    a          = '0;
    b          = '0;
    rst_n      = 1'b1;
    #1 rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    check("reset_out_valid", ov_o, 4'b0000);
    check("reset_o_result", res_o[0], 32'h0);
    check("reset_ovr", ovr_o, 4'b0000);
    check("reset_sticky", st_o, 4'b0000);
    check("reset_in_ready", ir_o, 4'b1111);

    run_one(32'h00060000, 32'h00080000, lat);
    check("latency", lat, STAGES);
    check("mul_1p5x2", res_o[0], 32'h000C0000);
    check("mul_1p5x2_ovr", ovr_o[0], 1'b0);
    run_one(32'hFFFA0000, 32'h00080000, lat);
    check("mul_m1p5x2", res_o[0], 32'hFFF40000);

    run_one(32'h00000001, 32'h00020000, lat);
    check("round_pos_r1", res_o[0], 32'h00000001);
    check("round_pos_r0", res_o[1], 32'h00000000);
    run_one(32'hFFFFFFFF, 32'h00020000, lat);
    check("round_neg_r1", res_o[0], 32'h00000000);
    check("round_neg_r0", res_o[1], 32'hFFFFFFFF);

    run_one(32'h01900000, 32'h01900000, lat);
    check("sat_pos", res_o[0], 32'h7FFFFFFF);
    check("sat_pos_ovr", ovr_o[0], 1'b1);
    check("wrap_pos", res_o[2], 32'h9C400000);
    run_one(32'h01900000, 32'hFE700000, lat);
    check("sat_neg", res_o[0], 32'h80000000);
    check("sat_neg_ovr", ovr_o[0], 1'b1);
    check("wrap_neg", res_o[2], 32'h63C00000);
    run_one(32'h80000000, 32'h80000000, lat);
    check("sat_minsq", res_o[0], 32'h7FFFFFFF);
    check("sat_minsq_ovr", ovr_o[0], 1'b1);
    check("wrap_minsq", res_o[2], 32'h00000000);
    @(posedge clk); #1;
    check("sticky_set", st_o, 4'b1111);

    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    check("sticky_clear", st_o, 4'b0000);

    run_one(32'h01900000, 32'h01900000, lat);
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    check("sticky_set_wins", st_o, 4'b1111);

    n0  = n_consumed;
    idx = 0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 6);
      if (idx < 5) begin
        in_valid = 1'b1;
        a = bp_a[idx];
        b = bp_b[idx];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      acc = in_valid && ir_o[0];
      @(posedge clk); #1;
      if (acc) idx++;
    end
    out_ready = 1'b1;
    check("bp_accepted", idx, 5);
    check("bp_consumed", n_consumed - n0, 5);

    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      a = 32'h01900000;
      b = 32'h01900000 + k;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("pre_reset_valid", ov_o[0], 1'b1);
    check("pre_reset_sticky", st_o[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", ov_o, 4'b0000);
    check("async_rst_result", res_o[0], 32'h0);
    check("async_rst_ovr", ovr_o, 4'b0000);
    check("async_rst_sticky", st_o, 4'b0000);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    seen = '0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      seen = seen | ov_o;
    end
    check("no_stale_after_reset", seen, 4'b0000);

    for (int k = 0; k < 10000; k++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      clr_sticky = ($urandom_range(0, 31) == 0);
      a          = rand_op();
      b          = rand_op();
      @(posedge clk); #1;
    end
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    clr_sticky = 1'b0;
    repeat (STAGES + 3) @(posedge clk);
    #1;
    check("drained", ov_o, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
